// File: rtl/equiv_sweep_ctrl.sv
// Clocked sweep sequencer that drives every input combination to N_FUNC original/simplified
// function pairs and accumulates mismatches. Optional first-fail capture: EQV_FIRST_FAIL_EN.
module equiv_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int N_FUNC = 5,
    parameter int FF_W   = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_FUNC-1:0] f_orig,
    input  logic [N_FUNC-1:0] f_simp,
    output logic [N_IN-1:0]   vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_FUNC-1:0] fail_mask,
    output logic [N_IN:0]     err_cnt
`ifdef EQV_FIRST_FAIL_EN
    ,
    output logic              ff_valid,
    output logic [N_IN-1:0]   ff_vec,
    output logic [FF_W-1:0]   ff_idx
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for start; results of the last sweep held
    // S_SWEEP | one input vector per cycle, mismatches accumulated on each edge
    typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t            r_state, w_state_nxt;
    logic [N_IN-1:0]   r_vec, w_vec_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pass, w_pass_nxt;
    logic [N_FUNC-1:0] r_fail_mask, w_fail_mask_nxt;
    logic [N_IN:0]     r_err_cnt, w_err_cnt_nxt;

    logic [N_FUNC-1:0] w_mm;
    logic              w_any_mm;
    logic              w_last;
    logic              w_accept;

    assign w_mm     = f_orig ^ f_simp;
    assign w_any_mm = |w_mm;
    assign w_last   = (r_vec == VEC_LAST);
    assign w_accept = (r_state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SWEEP;
            S_SWEEP: if (abort || w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_vec_nxt       = r_vec;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_fail_mask_nxt = r_fail_mask;
        w_err_cnt_nxt   = r_err_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_vec_nxt       = '0;
                    w_fail_mask_nxt = '0;
                    w_err_cnt_nxt   = '0;
                    w_busy_nxt      = 1'b1;
                    w_pass_nxt      = 1'b0;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    // partial fail_mask/err_cnt are left visible for debug
                    w_vec_nxt  = '0;
                    w_busy_nxt = 1'b0;
                    w_pass_nxt = 1'b0;
                end else begin
                    w_fail_mask_nxt = r_fail_mask | w_mm;
                    w_err_cnt_nxt   = r_err_cnt + {{N_IN{1'b0}}, w_any_mm};
                    if (w_last) begin
                        w_vec_nxt  = '0;
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                        w_pass_nxt = ~|(r_fail_mask | w_mm);
                    end else begin
                        w_vec_nxt = r_vec + 1'b1;
                    end
                end
            end
            default: begin
                w_vec_nxt  = '0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_vec       <= w_vec_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign vec       = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign err_cnt   = r_err_cnt;

`ifdef EQV_FIRST_FAIL_EN
    logic            r_ff_valid;
    logic [N_IN-1:0] r_ff_vec;
    logic [FF_W-1:0] r_ff_idx;
    logic [FF_W-1:0] w_low_idx;

    // scan from the top so the lowest mismatching index is the one left standing
    always_comb begin
        w_low_idx = '0;
        for (int i = N_FUNC - 1; i >= 0; i--) begin
            if (w_mm[i]) w_low_idx = FF_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_ff_idx   <= '0;
        end else if (w_accept) begin
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_ff_idx   <= '0;
        end else if (r_state == S_SWEEP && !abort && w_any_mm && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_vec   <= r_vec;
            r_ff_idx   <= w_low_idx;
        end
    end

    assign ff_valid = r_ff_valid;
    assign ff_vec   = r_ff_vec;
    assign ff_idx   = r_ff_idx;
`endif

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Scoreboard bench for equiv_sweep_ctrl (N_IN=2, N_FUNC=5): expected sweep results are queued
// by the stimulus and checked by a monitor on every done pulse.
module tb_equiv_sweep_ctrl;

    localparam int N_IN   = 2;
    localparam int N_FUNC = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [N_FUNC-1:0] f_orig;
    logic [N_FUNC-1:0] f_simp;
    logic [N_IN-1:0]   vec;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_FUNC-1:0] fail_mask;
    logic [N_IN:0]     err_cnt;
`ifdef EQV_FIRST_FAIL_EN
    logic              ff_valid;
    logic [N_IN-1:0]   ff_vec;
    logic [2:0]        ff_idx;
`endif

    equiv_sweep_ctrl #(.N_IN(N_IN), .N_FUNC(N_FUNC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_orig(f_orig), .f_simp(f_simp), .vec(vec), .busy(busy), .done(done),
        .pass(pass), .fail_mask(fail_mask), .err_cnt(err_cnt)
`ifdef EQV_FIRST_FAIL_EN
        , .ff_valid(ff_valid), .ff_vec(ff_vec), .ff_idx(ff_idx)
`endif
    );

    always #5 clk = ~clk;

    // function pairs: original = {x&y, x|y, x^y, ~x, y}; simplified = original ^ injected fault
    logic [N_FUNC-1:0] inj [0:3];
    always_comb begin
        f_orig = {vec[1] & vec[0], vec[1] | vec[0], vec[1] ^ vec[0], ~vec[1], vec[0]};
        f_simp = f_orig ^ inj[vec];
    end

    typedef struct packed {
        logic [4:0] fm;
        logic [2:0] err;
        logic       ps;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done_unexpected: got done=1 expected no pulse at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_fail_mask", int'(fail_mask), int'(e.fm));
                chk("sb_err_cnt", int'(err_cnt), int'(e.err));
                chk("sb_pass", int'(pass), int'(e.ps));
                chk("sb_busy_low", int'(busy), 0);
            end
        end
    end

    task automatic set_inj(input logic [4:0] i0, input logic [4:0] i1,
                           input logic [4:0] i2, input logic [4:0] i3);
        inj[0] = i0; inj[1] = i1; inj[2] = i2; inj[3] = i3;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
        end
    endtask

    // start pulse at a negedge; optionally walk the vector sequence and done latency
    task automatic sweep(input string name, input bit check_seq, input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (check_seq) begin
            for (int k = 0; k < 4; k++) begin
                chk({name, "_vec"}, int'(vec), k);
                chk({name, "_busy"}, int'(busy), 1);
                @(negedge clk);
            end
            chk({name, "_done_lat"}, int'(done), 1);
            chk({name, "_vec_end"}, int'(vec), 0);
        end else begin
            wait_done(name);
        end
    endtask

    initial begin
        set_inj(5'b0, 5'b0, 5'b0, 5'b0);
        #12;
        chk("rst_vec", int'(vec), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_fail_mask", int'(fail_mask), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // abort while idle must not start anything
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);
        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);

        // 1: clean sweep
        sweep("t1", 1'b1, '{fm: 5'b00000, err: 3'd0, ps: 1'b1});
        @(negedge clk);
        chk("t1_done_one_cycle", int'(done), 0);

        // 2: pair 4 wrong at vec=01
        set_inj(5'b0, 5'b10000, 5'b0, 5'b0);
        sweep("t2", 1'b0, '{fm: 5'b10000, err: 3'd1, ps: 1'b0});
`ifdef EQV_FIRST_FAIL_EN
        chk("t2_ff_valid", int'(ff_valid), 1);
        chk("t2_ff_vec", int'(ff_vec), 1);
        chk("t2_ff_idx", int'(ff_idx), 4);
`endif

        // 3: pairs 0 and 2 wrong at vec=11, counted as one vector
        set_inj(5'b0, 5'b0, 5'b0, 5'b00101);
        sweep("t3", 1'b0, '{fm: 5'b00101, err: 3'd1, ps: 1'b0});
`ifdef EQV_FIRST_FAIL_EN
        chk("t3_ff_vec", int'(ff_vec), 3);
        chk("t3_ff_idx", int'(ff_idx), 0);
`endif

        // multi-vector accumulation
        set_inj(5'b00001, 5'b00010, 5'b0, 5'b00001);
        sweep("tm", 1'b0, '{fm: 5'b00011, err: 3'd3, ps: 1'b0});

        // 4: abort at vec=10; partial results from vec 00 and 01 remain
        set_inj(5'b00010, 5'b0, 5'b01000, 5'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_vec_at_abort", int'(vec), 2);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t4_busy", int'(busy), 0);
        chk("t4_vec", int'(vec), 0);
        chk("t4_pass", int'(pass), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_partial_mask", int'(fail_mask), 5'b00010);
        chk("t4_partial_err", int'(err_cnt), 1);
        repeat (4) @(negedge clk);
        chk("t4_still_idle", int'(busy), 0);
        set_inj(5'b0, 5'b0, 5'b0, 5'b0);
        sweep("t4b", 1'b1, '{fm: 5'b00000, err: 3'd0, ps: 1'b1});

        // 5: start held through sweep, then still high in the done cycle
        exp_q.push_back('{fm: 5'b00000, err: 3'd0, ps: 1'b1});
        @(negedge clk); start = 1'b1;
        wait_done("t5a");
        set_inj(5'b0, 5'b0, 5'b01000, 5'b0);
        exp_q.push_back('{fm: 5'b01000, err: 3'd1, ps: 1'b0});
        @(negedge clk); start = 1'b0;
        chk("t5_restart_busy", int'(busy), 1);
        chk("t5_restart_vec", int'(vec), 0);
        chk("t5_cleared_mask", int'(fail_mask), 0);
        chk("t5_cleared_err", int'(err_cnt), 0);
        wait_done("t5b");

        // 6: async reset at vec=01
        set_inj(5'b11111, 5'b0, 5'b0, 5'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("t6_vec_before", int'(vec), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vec", int'(vec), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_fail_mask", int'(fail_mask), 0);
        chk("t6_err_cnt", int'(err_cnt), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_busy", int'(busy), 0);
        chk("t6_idle_vec", int'(vec), 0);
        set_inj(5'b0, 5'b0, 5'b0, 5'b0);
        sweep("t6b", 1'b1, '{fm: 5'b00000, err: 3'd0, ps: 1'b1});

        repeat (3) @(negedge clk);
        chk("sb_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
